// File: rtl/obi_interconnect_rsp_router_if.sv
// Response-router bus bundle: address-accept handshake in, slave response in,
// per-master response out. The router connects through the slave modport.
interface obi_interconnect_rsp_router_if #(
    parameter int unsigned MASTERS     = 3,
    parameter int unsigned MASTER_BITS = (MASTERS == 1) ? 1 : $clog2(MASTERS)
);
    logic                         accept_i;
    logic [MASTER_BITS-1:0]       accept_master_i;
    logic                         can_accept_o;
    logic                         slave_rvalid_i;
    logic [31:0]                  slave_rdata_i;
    logic                         slave_err_i;
    logic [MASTERS-1:0]           master_rvalid_o;
    logic [MASTERS-1:0][31:0]     master_rdata_o;
    logic [MASTERS-1:0]           master_err_o;

    // Arbiter/slave side: drives the accept handshake and the raw slave response
    modport master (
        output accept_i, accept_master_i,
        output slave_rvalid_i, slave_rdata_i, slave_err_i,
        input  can_accept_o,
        input  master_rvalid_o, master_rdata_o, master_err_o
    );

    // Router side
    modport slave (
        input  accept_i, accept_master_i,
        input  slave_rvalid_i, slave_rdata_i, slave_err_i,
        output can_accept_o,
        output master_rvalid_o, master_rdata_o, master_err_o
    );
endinterface

// File: rtl/obi_interconnect_rsp_router.sv
// Per-slave OBI response router: in-order FIFO of owning master IDs steers each
// slave response to its master. Define OBI_RSP_ERR_EN to forward slave_err_i.
module obi_interconnect_rsp_router #(
    parameter int unsigned MASTERS     = 3,
    parameter int unsigned MASTER_BITS = (MASTERS == 1) ? 1 : $clog2(MASTERS),
    parameter int unsigned OUTSTANDING = 2,
    parameter int unsigned CNT_BITS    = $clog2(OUTSTANDING + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    obi_interconnect_rsp_router_if.slave  bus,
    output logic [CNT_BITS-1:0]           outstanding_o,
    output logic                          proto_err_o
);

    localparam int unsigned           PTR_BITS = (OUTSTANDING == 1) ? 1 : $clog2(OUTSTANDING);
    localparam logic [CNT_BITS-1:0]   FULL_CNT = CNT_BITS'(OUTSTANDING);
    localparam logic [PTR_BITS-1:0]   LAST_PTR = PTR_BITS'(OUTSTANDING - 1);

    logic [MASTER_BITS-1:0] ids_q [OUTSTANDING];
    logic [PTR_BITS-1:0]    wptr_q, wptr_d;
    logic [PTR_BITS-1:0]    rptr_q, rptr_d;
    logic [CNT_BITS-1:0]    count_q, count_d;
    logic                   proto_err_q, proto_err_d;

    logic                   full_c;
    logic                   empty_c;
    logic                   push_c;
    logic                   pop_c;
    logic                   head_ok_c;
    logic [MASTER_BITS-1:0] head_c;

    // FIFO status and transfer qualifiers, all from registered state plus live inputs
    always_comb begin
        full_c    = (count_q == FULL_CNT);
        empty_c   = (count_q == '0);
        push_c    = bus.accept_i & ~full_c;
        pop_c     = bus.slave_rvalid_i & ~empty_c;
        head_c    = ids_q[rptr_q];
        head_ok_c = (32'(head_c) < MASTERS);
    end

    // Pointer, occupancy and sticky error next-state
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        proto_err_d = proto_err_q;

        if (push_c) begin
            wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_BITS'(1);
        end
        if (pop_c) begin
            rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_BITS'(1);
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase

        // Overflowing push, orphan response, or a stored ID naming no master
        if ((bus.accept_i & full_c) | (bus.slave_rvalid_i & empty_c) | (pop_c & ~head_ok_c)) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
        end
    end

    // ID storage carries no reset; only entries between the pointers are meaningful
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            ids_q[wptr_q] <= bus.accept_master_i;
        end
    end

    // Zero-latency response steering; data is broadcast and qualified by rvalid
    always_comb begin
        bus.master_rvalid_o = '0;
        bus.master_rdata_o  = '0;
        bus.master_err_o    = '0;
        for (int unsigned m = 0; m < MASTERS; m++) begin
            bus.master_rvalid_o[m] = pop_c & (head_c == MASTER_BITS'(m));
            bus.master_rdata_o[m]  = bus.slave_rdata_i;
`ifdef OBI_RSP_ERR_EN
            bus.master_err_o[m]    = bus.slave_err_i & pop_c & (head_c == MASTER_BITS'(m));
`else
            bus.master_err_o[m]    = 1'b0;
`endif
        end
    end

`ifndef OBI_RSP_ERR_EN
    logic unused_err_c;
    assign unused_err_c = bus.slave_err_i;
`endif

    assign bus.can_accept_o = ~full_c;
    assign outstanding_o    = count_q;
    assign proto_err_o      = proto_err_q;

endmodule

// File: tb/tb_obi_interconnect_rsp_router.sv
// Scoreboard bench for obi_interconnect_rsp_router: directed scenarios then
// randomized traffic against a queue-based model of the ID FIFO.
module tb_obi_interconnect_rsp_router;

    localparam int unsigned M   = 3;
    localparam int unsigned MB  = 2;
    localparam int unsigned O   = 2;
    localparam int unsigned CB  = $clog2(O + 1);

    typedef struct {
        logic [M-1:0] rv;
        logic [M-1:0] er;
        logic [31:0]  rd;
    } rsp_t;

    typedef struct {
        int cnt;
        bit ca;
        bit pe;
    } st_t;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [CB-1:0] outstanding;
    logic          proto_err;

    int checks = 0;
    int errors = 0;

    int   mq[$];
    bit   perr = 1'b0;
    rsp_t exp_q[$];
    st_t  st_q[$];

    obi_interconnect_rsp_router_if #(.MASTERS(M)) bus ();

    obi_interconnect_rsp_router #(
        .MASTERS    (M),
        .OUTSTANDING(O)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .bus          (bus),
        .outstanding_o(outstanding),
        .proto_err_o  (proto_err)
    );

    always #5 clk = ~clk;

    // One stimulus cycle: drive inputs after the edge, queue expectations, advance the model
    task automatic drive(input bit acc, input int am, input bit rv, input logic [31:0] rd, input bit er);
        rsp_t e;
        st_t  s;
        int   cnt;
        bit   popped;
        @(posedge clk);
        #1;
        rst_i               = 1'b0;
        bus.accept_i        = acc;
        bus.accept_master_i = MB'(am);
        bus.slave_rvalid_i  = rv;
        bus.slave_rdata_i   = rd;
        bus.slave_err_i     = er;

        cnt  = mq.size();
        s.cnt = cnt;
        s.ca  = (cnt != O);
        s.pe  = perr;
        st_q.push_back(s);

        e.rv = '0;
        e.er = '0;
        e.rd = rd;
        if (rv && cnt > 0 && mq[0] < M) e.rv[mq[0]] = 1'b1;
`ifdef OBI_RSP_ERR_EN
        if (er) e.er = e.rv;
`endif
        if (rv) exp_q.push_back(e);

        popped = rv && cnt > 0;
        if (acc && cnt == O) perr = 1'b1;
        if (rv && cnt == 0) perr = 1'b1;
        if (popped && mq[0] >= M) perr = 1'b1;
        if (popped) void'(mq.pop_front());
        if (acc && cnt != O) mq.push_back(am);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_i               = 1'b1;
        bus.accept_i        = 1'b0;
        bus.accept_master_i = '0;
        bus.slave_rvalid_i  = 1'b0;
        bus.slave_rdata_i   = '0;
        bus.slave_err_i     = 1'b0;
        mq.delete();
        perr = 1'b0;
    endtask

    // Monitor: status every active cycle, response whenever one is presented
    always @(negedge clk) begin
        st_t  s;
        rsp_t e;
        if (!rst_i) begin
            checks++;
            if (st_q.size() == 0) begin
                errors++;
                $display("FAIL status: no expectation queued at %0t", $time);
            end else begin
                s = st_q.pop_front();
                if (int'(outstanding) != s.cnt || bus.can_accept_o != s.ca || proto_err != s.pe) begin
                    errors++;
                    $display("FAIL status @%0t: outstanding=%0d can_accept=%0b proto_err=%0b, expected %0d %0b %0b",
                             $time, outstanding, bus.can_accept_o, proto_err, s.cnt, s.ca, s.pe);
                end
            end
            if (bus.slave_rvalid_i || (|bus.master_rvalid_o)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL response: unexpected master_rvalid=%b at %0t", bus.master_rvalid_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.master_rvalid_o != e.rv || bus.master_err_o != e.er) begin
                        errors++;
                        $display("FAIL response @%0t: rvalid=%b err=%b, expected rvalid=%b err=%b",
                                 $time, bus.master_rvalid_o, bus.master_err_o, e.rv, e.er);
                    end
                    for (int m = 0; m < M; m++) begin
                        if (bus.master_rdata_o[m] != e.rd) begin
                            errors++;
                            $display("FAIL rdata[%0d] @%0t: got %h, expected %h", m, $time, bus.master_rdata_o[m], e.rd);
                        end
                    end
                end
            end
        end
    end

    initial begin
        bus.accept_i        = 1'b0;
        bus.accept_master_i = '0;
        bus.slave_rvalid_i  = 1'b0;
        bus.slave_rdata_i   = '0;
        bus.slave_err_i     = 1'b0;
        repeat (3) @(posedge clk);

        idle(2);

        // single transaction to master 2, answered two cycles later
        drive(1'b1, 2, 1'b0, 32'h0, 1'b0);
        idle(2);
        drive(1'b0, 0, 1'b1, 32'hDEADBEEF, 1'b0);
        idle(1);

        // fill to capacity, drain in order
        drive(1'b1, 1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 0, 1'b0, 32'h0, 1'b0);
        idle(1);
        drive(1'b0, 0, 1'b1, 32'h11111111, 1'b0);
        drive(1'b0, 0, 1'b1, 32'h22222222, 1'b0);
        idle(1);

        // simultaneous push and pop at count 1
        drive(1'b1, 1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 0, 1'b1, 32'h33333333, 1'b0);
        drive(1'b0, 0, 1'b1, 32'h44444444, 1'b0);
        idle(1);

        // error forwarding to master 1
        drive(1'b1, 1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 0, 1'b1, 32'h55555555, 1'b1);
        idle(1);

        // orphan response sets the sticky flag
        drive(1'b0, 0, 1'b1, 32'h66666666, 1'b0);
        idle(3);

        // push while full, then push while full with same-cycle pop
        do_reset();
        drive(1'b1, 0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 2, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 2, 1'b1, 32'h77777777, 1'b0);
        drive(1'b0, 0, 1'b1, 32'h88888888, 1'b0);
        drive(1'b0, 0, 1'b1, 32'h99999999, 1'b0);
        idle(2);

        // out-of-range stored ID
        do_reset();
        drive(1'b1, 3, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 2, 1'b1, 32'hAAAAAAAA, 1'b1);
        drive(1'b0, 0, 1'b1, 32'hBBBBBBBB, 1'b1);
        idle(1);

        // randomized traffic with occasional mid-operation reset
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                drive(1'($urandom_range(0, 1)),
                      ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, M - 1)),
                      1'($urandom_range(0, 1)),
                      $urandom,
                      1'($urandom_range(0, 1)));
            end
        end
        idle(2);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || st_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses and %0d status entries left unchecked", exp_q.size(), st_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/obi_interconnect_rsp_router.md
Name: obi_interconnect_rsp_router

Overview:
- Response-path companion to the per-slave request arbiter in the OBI system bus.
- Records which master owns each address phase accepted by one slave port, in an in-order ID FIFO.
- On each slave rvalid, steers rvalid/rdata/err back to the master at the FIFO head, then retires that entry.
- One instance per slave port, placed between the slave and the master-side response muxes.

Parameters:
- MASTERS, 3, number of masters sharing this slave port.
- MASTER_BITS, (MASTERS==1 ? 1 : $clog2(MASTERS)), width of a master index.
- OUTSTANDING, 2, maximum accepted-but-unanswered transactions (FIFO depth, >=1).
- CNT_BITS, $clog2(OUTSTANDING+1), width of the occupancy count.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- accept_i  input  1  address phase accepted this cycle (slave req & gnt).
- accept_master_i  input  MASTER_BITS  index of granted master for the accepted phase.
- can_accept_o  output  1  FIFO not full; arbiter must gate grant with this.
- slave_rvalid_i  input  1  response valid from slave.
- slave_rdata_i  input  32  response data from slave.
- slave_err_i  input  1  response error from slave.
- master_rvalid_o [MASTERS]  output  1 each  per-master response valid.
- master_rdata_o [MASTERS]  output  32 each  per-master response data.
- master_err_o [MASTERS]  output  1 each  per-master response error.
- outstanding_o  output  CNT_BITS  current FIFO occupancy.
- proto_err_o  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst_i high at edge): write ptr, read ptr, count = 0; proto_err_o = 0. Stored IDs are don't-care.
- Reset mid-operation: all outstanding IDs discarded. Later responses count as unexpected.
- Out of reset: can_accept_o = 1, outstanding_o = 0, all master_rvalid_o = 0.
- Push: accept_i=1 and count<OUTSTANDING → store accept_master_i at wptr; wptr wraps OUTSTANDING-1→0.
- Pop: slave_rvalid_i=1 and count>0 → retire head; rptr wraps the same way.
- Simultaneous push+pop: count unchanged. Allowed only when count<OUTSTANDING.
- can_accept_o = (count != OUTSTANDING). Depends on registered state only, so no combinational path from rvalid.
- Response routing is combinational, zero added latency:
  - master_rvalid_o[m] = slave_rvalid_i & (count>0) & (head == m).
  - master_rdata_o[m] = slave_rdata_i for every m (broadcast; consumers qualify with rvalid).
- Responses return strictly in acceptance order; the slave is required to respond in order.
- Push while full (accept_i=1, count==OUTSTANDING, even with same-cycle pop): entry dropped, proto_err_o set.
- Rvalid while empty: no master_rvalid_o asserted, no pointer change, proto_err_o set.
- Head index >= MASTERS: entry popped normally, no master_rvalid_o asserted, proto_err_o set.
- proto_err_o clears only on reset.
- Accepting an address phase and responding to it in the same cycle is illegal for OBI. No bypass is provided.

Optional Feature:
- Macro: OBI_RSP_ERR_EN.
- Defined: master_err_o[m] = slave_err_i & master_rvalid_o[m].
- Undefined: master_err_o tied to 0, slave_err_i ignored.
- Ports exist in both builds.

Test Plan:
- Reset then idle: outstanding_o=0, can_accept_o=1, proto_err_o=0, all master_rvalid_o=0.
- Accept master 2, then rvalid with rdata=0xDEADBEEF two cycles later → only master_rvalid_o[2]=1 with rdata 0xDEADBEEF; outstanding_o goes 1→0.
- Accept masters 1 then 0 back-to-back (OUTSTANDING=2) → can_accept_o=0; rvalids routed to master 1 then master 0; can_accept_o returns to 1 after the first pop.
- Count=1, same-cycle accept of master 0 and rvalid → response goes to old head; count stays 1; next rvalid goes to master 0.
- Rvalid with empty FIFO, and separately accept_i while full → no master_rvalid_o, pointers unchanged, proto_err_o=1 held until rst_i.
- Build with OBI_RSP_ERR_EN: accept master 1, rvalid with slave_err_i=1 → master_err_o[1]=1, others 0. Build without the macro → master_err_o all 0.
